alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Multi-cycle execute sequencer between the ALU decoder and the writeback stage.
//  Accepts one decoded ALU op per handshake. Non-shift ops complete in 1 cycle.
//  SLL/SRL/SRA run on an iterative 1-bit (optionally 4-bit) shifter instead of a barrel shifter.
//  Drives busy so the hazard/stall logic freezes upstream stages while a shift runs.
// PARAMETERS
//  DATA_WIDTH   32  operand/result width
//  SHAMT_WIDTH  5   shift-amount width (= log2 DATA_WIDTH)
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous active-low reset
//  in_valid   in   1           op request; sampled only when in_ready=1
//  in_ready   out  1           = (state==IDLE)
//  alu_ctrl   in   4           ALUControl code, see alu_pkg
//  src_a      in   DATA_WIDTH  operand A (value to shift for shifts)
//  src_b      in   DATA_WIDTH  operand B; [SHAMT_WIDTH-1:0] = shamt for shifts
//  flush      in   1           abort in-flight op (branch mispredict/trap)
//  out_valid  out  1           one-cycle pulse: result/zero valid
//  result     out  DATA_WIDTH  registered result
//  zero       out  1           registered (result==0), for branch resolution
//  busy       out  1           = (state==SHIFT); stall request to the pipeline
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, zero=1, busy=0, counter=0.
//   Reset mid-SHIFT discards the op immediately. No out_valid is produced for it.
//  Codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 sll, 0101 slt (signed), 0110 srl,
//   0111 sra, 1000 sltu, 1001 xor. Any other code gives result=0 and still pulses out_valid.
//  Arithmetic: add/sub wrap mod 2^DATA_WIDTH. slt/sltu give 1 or 0, zero-extended.
//  States: IDLE, SHIFT.
//   IDLE, accept (in_valid & ~flush), non-shift op or shamt==0:
//    result is registered at the accepting edge. out_valid=1 in the next cycle; state stays IDLE.
//    Throughput is 1 op/cycle.
//   IDLE, accept, shift op with shamt N>0:
//    load acc=src_a, cnt=N, latch op kind, go to SHIFT.
//   SHIFT: each cycle acc shifts 1 bit and cnt decrements.
//    sll: zero fill. srl: zero fill. sra: fills with sign bit of the original src_a.
//    When cnt reaches 0, return to IDLE with out_valid=1 and result=acc.
//  Latency: an op accepted in cycle T gives out_valid in cycle T+N+1 (non-shift: T+1).
//   In the out_valid cycle the block is IDLE and accepts a new op.
//  flush: highest priority in every state. Any in-flight shift is dropped and state goes to IDLE.
//   No out_valid for the dropped op. A same-cycle in_valid is ignored.
//   An out_valid already scheduled for the next cycle from a 1-cycle op is suppressed.
//  out_valid is never asserted for two ops in the same cycle.
//   result/zero hold their last value when out_valid=0.
// CONFIGURATION
//  SEQ_SHIFT4_EN defined: in SHIFT, step by 4 bits while cnt>=4, otherwise by 1 bit.
//   Latency = N/4 + N%4 + 1 cycles. Example: N=31 takes 11 cycles.
//  SEQ_SHIFT4_EN undefined: 1 bit/cycle, latency N+1. 4-bit step logic is not built.
//  Results are identical in both builds; only timing differs.
// STRUCTURE
//  alu_pkg: ALU_* 4-bit code localparams and the seq_state_t enum {IDLE, SHIFT}.
//   The same codes are used by the ALU decoder.
//  Sub-module alu_shift_step: combinational single step.
//   Inputs: acc, dir, arith, sign, step4. Output: next acc.
//   Instantiated once; the counter/FSM stays in this module.
// TESTING
//  1. add 5+7 at T -> out_valid@T+1, result=12, zero=0.
//     sub 7-7 next cycle -> out_valid@T+2, result=0, zero=1.
//  2. Back-to-back xor(0xF0,0xFF), or(1,2), slt(-1,1) on consecutive cycles
//     -> consecutive out_valid with results 0x0F, 3, 1.
//     sltu(0xFFFFFFFF,1) -> 0.
//  3. sll src_a=1, shamt=31 -> busy and in_ready=0 for 31 cycles, result=0x80000000 @T+32.
//     With SEQ_SHIFT4_EN: @T+11.
//  4. sra 0x80000000 by 4 -> 0xF8000000 @T+5 (SEQ_SHIFT4_EN: @T+2).
//     srl with same operands -> 0x08000000. Shift with shamt=0 -> src_a unchanged @T+1.
//  5. flush in 3rd SHIFT cycle of an sll with shamt=10 -> no out_valid, in_ready=1 next cycle.
//     flush together with in_valid in IDLE -> op dropped, no out_valid.
//  6. rst_n low mid-shift -> busy=0, out_valid=0, result=0 immediately.
//     After release, add 1+1 -> result=2 @T+1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control codes and sequencer state encoding.
// Also used by the ALU decoder so both sides agree on the op numbering.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } seq_state_t;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response bundle between the ALU decoder (master) and the execute sequencer (slave).
interface alu_op_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            alu_ctrl;
  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  logic                  flush;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] result;
  logic                  zero;
  logic                  busy;

  modport master (
    output in_valid, alu_ctrl, src_a, src_b, flush,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, alu_ctrl, src_a, src_b, flush,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_shift_step.sv
// Combinational single step of the iterative shifter: 1 bit, or 4 bits when SEQ_SHIFT4_EN
// is defined and step4_i is set.
module alu_shift_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] acc_i,
  input  logic                  dir_i,    // 1 = left
  input  logic                  arith_i,
  input  logic                  sign_i,
  input  logic                  step4_i,
  output logic [DATA_WIDTH-1:0] acc_o
);
  logic                  fill;
  logic [DATA_WIDTH-1:0] acc1;

  // Sign fill comes from the original operand, so it does not depend on acc contents.
  assign fill = arith_i & sign_i;
  assign acc1 = dir_i ? {acc_i[DATA_WIDTH-2:0], 1'b0}
                      : {fill, acc_i[DATA_WIDTH-1:1]};

`ifdef SEQ_SHIFT4_EN
  logic [DATA_WIDTH-1:0] acc4;
  assign acc4  = dir_i ? {acc_i[DATA_WIDTH-5:0], 4'b0000}
                       : {{4{fill}}, acc_i[DATA_WIDTH-1:4]};
  assign acc_o = step4_i ? acc4 : acc1;
`else
  logic step4_unused;
  assign step4_unused = step4_i;
  assign acc_o        = acc1;
`endif
endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle execute sequencer: single-cycle ALU ops plus iterative SLL/SRL/SRA.
// Define SEQ_SHIFT4_EN to let the shifter step 4 bits per cycle while the count allows.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_op_sequencer_if.slave bus
);
  seq_state_t             state_q, state_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic                   dir_q, dir_d;
  logic                   arith_q, arith_d;
  logic                   sign_q, sign_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   zero_q, zero_d;
  logic                   out_valid_q, out_valid_d;

  logic [SHAMT_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0]  alu_res;
  logic [DATA_WIDTH-1:0]  acc_step;
  logic                   step4;
  logic [SHAMT_WIDTH-1:0] step_amt;
  logic [SHAMT_WIDTH-1:0] cnt_dec;

  assign shamt = bus.src_b[SHAMT_WIDTH-1:0];

`ifdef SEQ_SHIFT4_EN
  assign step4    = (cnt_q >= SHAMT_WIDTH'(4));
  assign step_amt = step4 ? SHAMT_WIDTH'(4) : SHAMT_WIDTH'(1);
`else
  assign step4    = 1'b0;
  assign step_amt = SHAMT_WIDTH'(1);
`endif
  assign cnt_dec = cnt_q - step_amt;

  alu_shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_shift_step (
    .acc_i   (acc_q),
    .dir_i   (dir_q),
    .arith_i (arith_q),
    .sign_i  (sign_q),
    .step4_i (step4),
    .acc_o   (acc_step)
  );

  // Single-cycle result; shift codes only land here when shamt==0, so they pass src_a.
  always_comb begin
    alu_res = '0;
    case (bus.alu_ctrl)
      ALU_ADD:  alu_res = bus.src_a + bus.src_b;
      ALU_SUB:  alu_res = bus.src_a - bus.src_b;
      ALU_AND:  alu_res = bus.src_a & bus.src_b;
      ALU_OR:   alu_res = bus.src_a | bus.src_b;
      ALU_XOR:  alu_res = bus.src_a ^ bus.src_b;
      ALU_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      ALU_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (bus.src_a < bus.src_b)};
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = bus.src_a;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    dir_d       = dir_q;
    arith_d     = arith_q;
    sign_d      = sign_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;

    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (is_shift(bus.alu_ctrl) && (shamt != '0)) begin
              state_d = SHIFT;
              acc_d   = bus.src_a;
              cnt_d   = shamt;
              dir_d   = (bus.alu_ctrl == ALU_SLL);
              arith_d = (bus.alu_ctrl == ALU_SRA);
              sign_d  = bus.src_a[DATA_WIDTH-1];
            end else begin
              result_d    = alu_res;
              zero_d      = (alu_res == '0);
              out_valid_d = 1'b1;
            end
          end
        end
        SHIFT: begin
          acc_d = acc_step;
          cnt_d = cnt_dec;
          if (cnt_dec == '0) begin
            state_d     = IDLE;
            result_d    = acc_step;
            zero_d      = (acc_step == '0);
            out_valid_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      dir_q       <= 1'b0;
      arith_q     <= 1'b0;
      sign_q      <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      dir_q       <= dir_d;
      arith_q     <= arith_d;
      sign_q      <= sign_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == SHIFT);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer; latency expectations follow SEQ_SHIFT4_EN.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  alu_op_sequencer_if #(.DATA_WIDTH(32)) bus ();

  alu_op_sequencer #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = op;
    bus.src_a    = a;
    bus.src_b    = b;
    $display("[%0t] issue op=%b a=%h b=%h", $time, op, a, b);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.alu_ctrl = 4'b0000;
    bus.src_a    = '0;
    bus.src_b    = '0;
  endtask

  function automatic int shift_lat(input int n);
`ifdef SEQ_SHIFT4_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  task automatic run_shift(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input int n, input logic [31:0] exp);
    int c;
    drive(op, a, 32'(n));
    tick();
    idle();
    c = 1;
    while (bus.out_valid !== 1'b1 && c < 80) begin
      check({tag, " busy"}, {31'b0, bus.busy}, 32'd1);
      check({tag, " in_ready"}, {31'b0, bus.in_ready}, 32'd0);
      tick();
      c++;
    end
    check({tag, " latency"}, 32'(c), 32'(shift_lat(n)));
    check({tag, " out_valid"}, {31'b0, bus.out_valid}, 32'd1);
    check({tag, " result"}, bus.result, exp);
    check({tag, " idle_busy"}, {31'b0, bus.busy}, 32'd0);
    $display("[%0t] %s done result=%h cycles=%0d", $time, tag, bus.result, c);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    bus.flush  = 1'b0;
    idle();
    tick();
    tick();
    check("rst out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst result", bus.result, 32'd0);
    check("rst zero", {31'b0, bus.zero}, 32'd1);
    check("rst busy", {31'b0, bus.busy}, 32'd0);
    check("rst in_ready", {31'b0, bus.in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // 1: add then sub back to back
    drive(ALU_ADD, 32'd5, 32'd7);
    tick();
    check("add ov", {31'b0, bus.out_valid}, 32'd1);
    check("add result", bus.result, 32'd12);
    check("add zero", {31'b0, bus.zero}, 32'd0);
    drive(ALU_SUB, 32'd7, 32'd7);
    tick();
    check("sub ov", {31'b0, bus.out_valid}, 32'd1);
    check("sub result", bus.result, 32'd0);
    check("sub zero", {31'b0, bus.zero}, 32'd1);

    // 2: consecutive logic/compare ops
    drive(ALU_XOR, 32'h0000_00F0, 32'h0000_00FF);
    tick();
    check("xor ov", {31'b0, bus.out_valid}, 32'd1);
    check("xor result", bus.result, 32'h0000_000F);
    drive(ALU_OR, 32'd1, 32'd2);
    tick();
    check("or ov", {31'b0, bus.out_valid}, 32'd1);
    check("or result", bus.result, 32'd3);
    drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    tick();
    check("slt ov", {31'b0, bus.out_valid}, 32'd1);
    check("slt result", bus.result, 32'd1);
    drive(ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
    tick();
    check("sltu result", bus.result, 32'd0);
    check("sltu zero", {31'b0, bus.zero}, 32'd1);
    drive(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
    tick();
    check("and result", bus.result, 32'h00F0_1200);
    drive(4'b1100, 32'd9, 32'd9);
    tick();
    check("illegal ov", {31'b0, bus.out_valid}, 32'd1);
    check("illegal result", bus.result, 32'd0);
    drive(ALU_ADD, 32'hFFFF_FFFF, 32'd2);
    tick();
    check("add wrap", bus.result, 32'd1);
    idle();
    tick();
    check("pulse end ov", {31'b0, bus.out_valid}, 32'd0);
    check("hold result", bus.result, 32'd1);

    // 3/4: iterative shifts
    run_shift("sll31", ALU_SLL, 32'd1, 31, 32'h8000_0000);
    run_shift("sra4", ALU_SRA, 32'h8000_0000, 4, 32'hF800_0000);
    run_shift("srl4", ALU_SRL, 32'h8000_0000, 4, 32'h0800_0000);
    run_shift("sra7pos", ALU_SRA, 32'h7000_0000, 7, 32'h00E0_0000);
    run_shift("sll0", ALU_SLL, 32'h0000_1234, 0, 32'h0000_1234);
    idle();
    tick();

    // 5: flush in the 3rd shift cycle, then flush alongside a request
    drive(ALU_SLL, 32'd1, 32'd10);
    tick();
    idle();
    check("flush busy1", {31'b0, bus.busy}, 32'd1);
    tick();
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("flush busy", {31'b0, bus.busy}, 32'd0);
    check("flush ov", {31'b0, bus.out_valid}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("flush no ov", {31'b0, bus.out_valid}, 32'd0);
    end
    check("flush hold result", bus.result, 32'h0000_1234);
    drive(ALU_ADD, 32'd1, 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle();
    check("flush+in ov", {31'b0, bus.out_valid}, 32'd0);
    check("flush+in result", bus.result, 32'h0000_1234);
    tick();
    check("flush+in ov2", {31'b0, bus.out_valid}, 32'd0);

    // 6: asynchronous reset in the middle of a shift
    drive(ALU_SLL, 32'd1, 32'd20);
    tick();
    idle();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("arst busy", {31'b0, bus.busy}, 32'd0);
    check("arst ov", {31'b0, bus.out_valid}, 32'd0);
    check("arst result", bus.result, 32'd0);
    check("arst zero", {31'b0, bus.zero}, 32'd1);
    tick();
    rst_n = 1'b1;
    drive(ALU_ADD, 32'd1, 32'd1);
    tick();
    idle();
    check("post-rst ov", {31'b0, bus.out_valid}, 32'd1);
    check("post-rst result", bus.result, 32'd2);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
